aes_stream_downsizer: RTL and testbench

Parametrised wide-to-narrow stream serializer for the AES HWPE datapath. It accepts one IN_W-bit word per handshake and emits it as RATIO = IN_W/OUT_W consecutive OUT_W-bit beats. Both sides use a full valid/ready handshake with back-pressure, and it sustains one output beat per cycle with no bubbles between words. It sits between the AES core output (128-bit state) and the 32-bit HWPE streamer sink, replacing the fixed 128→32 unstacker.

---
 rtl/aes_stream_downsizer.sv | 121 ++++++++++++
 tb/tb_aes_stream_downsizer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_downsizer.sv
// Wide-to-narrow stream serializer: one IN_W word in, RATIO = IN_W/OUT_W OUT_W beats out.
// Optional packet framing (in_last_i / out_last_o) is enabled by defining DOWNSIZER_LAST_EN.
module aes_stream_downsizer #(
  parameter int unsigned IN_W      = 128,
  parameter int unsigned OUT_W     = 32,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             enable_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
`ifdef DOWNSIZER_LAST_EN
  input  logic             in_last_i,
  output logic             out_last_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_param_check
    $error("aes_stream_downsizer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_d, state_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [IN_W-1:0]   word_d, word_q;
  logic              full_q;
  logic              last_idx;
  logic              beat_xfer;
  logic              word_accept;
`ifdef DOWNSIZER_LAST_EN
  logic              last_d, last_q;
`endif

  assign full_q      = (state_q == ST_FULL);
  assign last_idx    = (idx_q == IDX_LAST);
  assign out_valid_o = full_q;
  // Ready looks through to out_ready_i so a new word loads on the cycle the last beat leaves.
  assign in_ready_o  = enable_i & (~full_q | (last_idx & out_ready_i));
  assign beat_xfer   = full_q & out_ready_i & enable_i;
  assign word_accept = in_valid_i & in_ready_o;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
`ifdef DOWNSIZER_LAST_EN
    last_d  = last_q;
`endif
    if (clr_i) begin
      state_d = ST_EMPTY;
      idx_d   = '0;
      word_d  = '0;
`ifdef DOWNSIZER_LAST_EN
      last_d  = 1'b0;
`endif
    end else if (enable_i) begin
      if (beat_xfer) begin
        if (last_idx) begin
          idx_d   = '0;
          state_d = ST_EMPTY;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      // An accept overrides the retire above, keeping the register full.
      if (word_accept) begin
        word_d  = in_data_i;
        idx_d   = '0;
        state_d = ST_FULL;
`ifdef DOWNSIZER_LAST_EN
        last_d  = in_last_i;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      word_q  <= '0;
`ifdef DOWNSIZER_LAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
`ifdef DOWNSIZER_LAST_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    int unsigned      sel;
    logic [IN_W-1:0]  shifted;
    sel        = MSB_FIRST ? (RATIO - 1 - 32'(idx_q)) : 32'(idx_q);
    shifted    = word_q >> (sel * OUT_W);
    out_data_o = shifted[OUT_W-1:0];
  end

`ifdef DOWNSIZER_LAST_EN
  assign out_last_o = full_q & last_q & last_idx;
`endif

endmodule

// File: tb/tb_aes_stream_downsizer.sv
// Randomized and directed bench for aes_stream_downsizer; two instances (MSB-first and LSB-first)
// share the same stimulus and are compared against a word-queue reference model.
module tb_aes_stream_downsizer;

  localparam int IN_W  = 128;
  localparam int OUT_W = 32;
  localparam int RATIO = IN_W / OUT_W;

  logic              clk = 1'b0;
  logic              rst_n, clr, en, in_valid, in_last, out_ready;
  logic [IN_W-1:0]   in_data;
  logic              m_in_ready, m_out_valid, l_in_ready, l_out_valid;
  logic [OUT_W-1:0]  m_out_data, l_out_data;
`ifdef DOWNSIZER_LAST_EN
  logic              m_out_last, l_out_last;
`endif

  always #5 clk = ~clk;

  aes_stream_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(en),
    .in_valid_i(in_valid), .in_ready_o(m_in_ready), .in_data_i(in_data),
`ifdef DOWNSIZER_LAST_EN
    .in_last_i(in_last), .out_last_o(m_out_last),
`endif
    .out_valid_o(m_out_valid), .out_ready_i(out_ready), .out_data_o(m_out_data)
  );

  aes_stream_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(en),
    .in_valid_i(in_valid), .in_ready_o(l_in_ready), .in_data_i(in_data),
`ifdef DOWNSIZER_LAST_EN
    .in_last_i(in_last), .out_last_o(l_out_last),
`endif
    .out_valid_o(l_out_valid), .out_ready_i(out_ready), .out_data_o(l_out_data)
  );

  // Reference model: queue of accepted words plus the index of the next beat to emit.
  typedef struct packed {
    logic [IN_W-1:0] d;
    logic            l;
  } word_t;

  word_t       wq[$];
  int          beat;
  int          n_vec, n_err, n_acc, n_beats;
  bit          dir_on;
  logic [31:0] dir_m[4];
  logic [31:0] dir_l[4];

  function automatic logic [OUT_W-1:0] slice(logic [IN_W-1:0] w, int b, bit msb);
    int s;
    logic [IN_W-1:0] t;
    s = msb ? (RATIO - 1 - b) : b;
    t = w >> (s * OUT_W);
    return t[OUT_W-1:0];
  endfunction

  function automatic logic [IN_W-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(string tag, logic [IN_W-1:0] got, logic [IN_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit ev, er, xfer, acc;
    @(negedge clk);
    ev = (wq.size() > 0);
    er = en && (!ev || (beat == RATIO - 1 && out_ready));
    chk("valid_msb", 128'(m_out_valid), 128'(ev));
    chk("valid_lsb", 128'(l_out_valid), 128'(ev));
    chk("ready_msb", 128'(m_in_ready), 128'(er));
    chk("ready_lsb", 128'(l_in_ready), 128'(er));
    if (ev) begin
      chk("data_msb", 128'(m_out_data), 128'(slice(wq[0].d, beat, 1'b1)));
      chk("data_lsb", 128'(l_out_data), 128'(slice(wq[0].d, beat, 1'b0)));
      if (dir_on) begin
        chk("dir_msb", 128'(m_out_data), 128'(dir_m[beat]));
        chk("dir_lsb", 128'(l_out_data), 128'(dir_l[beat]));
      end
    end
`ifdef DOWNSIZER_LAST_EN
    chk("last_msb", 128'(m_out_last), 128'(ev && wq[0].l && beat == RATIO - 1));
    chk("last_lsb", 128'(l_out_last), 128'(ev && wq[0].l && beat == RATIO - 1));
`endif
    xfer = ev && out_ready && en;
    acc  = in_valid && er;
    @(posedge clk);
    if (clr) begin
      wq.delete();
      beat = 0;
    end else if (en) begin
      if (xfer) begin
        n_beats++;
        if (beat == RATIO - 1) begin
          wq.delete(0);
          beat = 0;
        end else begin
          beat++;
        end
      end
      if (acc) begin
        wq.push_back(word_t'({in_data, in_last}));
        n_acc++;
      end
    end
    #1;
  endtask

  task automatic send(logic [IN_W-1:0] d, logic l);
    int start;
    int k;
    start    = n_acc;
    k        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (n_acc == start && k < 50) begin
      step();
      k++;
    end
    in_valid = 1'b0;
    chk("send_accepted", 128'(n_acc - start), 128'd1);
  endtask

  initial begin
    int s0;
    int k;
    dir_m = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    dir_l = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    n_vec = 0; n_err = 0; n_acc = 0; n_beats = 0; beat = 0; dir_on = 1'b0;
    rst_n = 1'b0; clr = 1'b0; en = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_msb", 128'(m_out_valid), 128'd0);
    chk("rst_valid_lsb", 128'(l_out_valid), 128'd0);
    chk("rst_data_msb", 128'(m_out_data), 128'd0);
    chk("rst_data_lsb", 128'(l_out_data), 128'd0);
    chk("rst_ready", 128'(m_in_ready), 128'(en));
`ifdef DOWNSIZER_LAST_EN
    chk("rst_last", 128'(m_out_last), 128'd0);
`endif
    rst_n = 1'b1;
    step();

    // Directed single word, both beat orders.
    dir_on    = 1'b1;
    out_ready = 1'b1;
    send(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    repeat (4) step();
    dir_on = 1'b0;
    step();

    // Back-to-back words with the sink always ready: 12 beats, no gaps.
    s0       = n_acc;
    n_beats  = 0;
    in_valid = 1'b1;
    in_data  = rnd_word();
    for (int i = 0; i < 14; i++) begin
      step();
      in_data = rnd_word();
      if (n_acc - s0 >= 3) in_valid = 1'b0;
    end
    chk("b2b_words", 128'(n_acc - s0), 128'd3);
    chk("b2b_beats", 128'(n_beats), 128'd12);

    // Clear after beat 1; the following word must start again at beat 0.
    send(rnd_word(), 1'b0);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    send(rnd_word(), 1'b0);
    repeat (5) step();

    // Enable low for 5 cycles mid-word; emission resumes at the same beat.
    send(rnd_word(), 1'b0);
    step();
    en       = 1'b0;
    in_valid = 1'b1;
    in_data  = rnd_word();
    repeat (5) step();
    en       = 1'b1;
    in_valid = 1'b0;
    repeat (5) step();

    // Asynchronous reset mid-word drops the word immediately.
    send(rnd_word(), 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid_msb", 128'(m_out_valid), 128'd0);
    chk("arst_valid_lsb", 128'(l_out_valid), 128'd0);
    wq.delete();
    beat = 0;
    #2;
    rst_n = 1'b1;
    step();

`ifdef DOWNSIZER_LAST_EN
    // Packet framing: only the final beat of the last-flagged word carries last.
    send(rnd_word(), 1'b0);
    send(rnd_word(), 1'b1);
    repeat (6) step();
`endif

    // Random traffic: 100 words under random back-pressure and occasional stalls.
    s0 = n_acc;
    k  = 0;
    while (n_acc - s0 < 100 && k < 5000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = rnd_word();
      in_last   = $urandom_range(1) != 0;
      out_ready = $urandom_range(1) != 0;
      en        = ($urandom_range(15) != 0);
      clr       = 1'b0;
      step();
      k++;
    end
    chk("rand_words", 128'(n_acc - s0), 128'd100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    en        = 1'b1;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
